// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline:
// load-use stalls, branch redirects, memory wait/timeout and trap entry.
module pipeline_ctrl #(
  parameter int AWIDTH = 5,
  parameter int PC_WIDTH = 32,
  parameter int EWIDTH = 4,
  parameter int TIMEOUT = 16,
  parameter logic [PC_WIDTH-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic c_clk,
  input  logic c_rst,
  input  logic [AWIDTH-1:0] c_i_id_rs1,
  input  logic [AWIDTH-1:0] c_i_id_rs2,
  input  logic c_i_id_use_rs1,
  input  logic c_i_id_use_rs2,
  input  logic c_i_ex_valid,
  input  logic c_i_ex_load,
  input  logic [AWIDTH-1:0] c_i_ex_rd,
  input  logic c_i_ex_change_pc,
  input  logic [PC_WIDTH-1:0] c_i_ex_next_pc,
  input  logic [PC_WIDTH-1:0] c_i_ex_pc,
  input  logic [EWIDTH-1:0] c_i_ex_exception,
  input  logic c_i_mem_req,
  input  logic c_i_mem_ack,
  output logic c_o_stall_if,
  output logic c_o_stall_id,
  output logic c_o_stall_ex,
  output logic c_o_stall_mem,
  output logic c_o_flush_id,
  output logic c_o_flush_ex,
  output logic c_o_flush_mem,
  output logic c_o_redirect,
  output logic [PC_WIDTH-1:0] c_o_redirect_pc,
  output logic c_o_trap,
  output logic [EWIDTH-1:0] c_o_trap_cause,
  output logic [PC_WIDTH-1:0] c_o_trap_pc,
  output logic [1:0] c_o_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2,
    ILLEGAL  = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [EWIDTH-1:0] cause_q, cause_d;
  logic [PC_WIDTH-1:0] tpc_q, tpc_d;

  logic load_use;
  logic exc;
  logic busy;
  logic timeout;

  assign load_use = c_i_ex_valid && c_i_ex_load &&
                    (c_i_ex_rd != '0) &&
                    ((c_i_id_use_rs1 && (c_i_id_rs1 == c_i_ex_rd)) ||
                     (c_i_id_use_rs2 && (c_i_id_rs2 == c_i_ex_rd)));
  assign exc = c_i_ex_valid && (c_i_ex_exception != '0);
  assign busy = c_i_mem_req && !c_i_mem_ack;
  // cnt_q counts non-ack cycles already seen, so this is the TIMEOUT-th
  assign timeout = (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cause_d = cause_q;
    tpc_d = tpc_q;
    c_o_stall_if = 1'b0;
    c_o_stall_id = 1'b0;
    c_o_stall_ex = 1'b0;
    c_o_stall_mem = 1'b0;
    c_o_flush_id = 1'b0;
    c_o_flush_ex = 1'b0;
    c_o_flush_mem = 1'b0;
    c_o_redirect = 1'b0;
    c_o_redirect_pc = '0;
    c_o_trap = 1'b0;
    unique case (state_q)
      RUN: begin
        if (busy) begin
          c_o_stall_if = 1'b1;
          c_o_stall_id = 1'b1;
          c_o_stall_ex = 1'b1;
          c_o_stall_mem = 1'b1;
          cnt_d = 8'd1;
          state_d = MEM_WAIT;
        end else if (exc) begin
          c_o_flush_id = 1'b1;
          c_o_flush_ex = 1'b1;
          cause_d = c_i_ex_exception;
          tpc_d = c_i_ex_pc;
          state_d = TRAP;
        end else if (c_i_ex_valid && c_i_ex_change_pc) begin
          c_o_redirect = 1'b1;
          c_o_redirect_pc = c_i_ex_next_pc;
          c_o_flush_id = 1'b1;
          c_o_flush_ex = 1'b1;
        end else if (load_use) begin
          c_o_stall_if = 1'b1;
          c_o_stall_id = 1'b1;
          c_o_flush_ex = 1'b1;
        end
      end
      MEM_WAIT: begin
        c_o_stall_if = !c_i_mem_ack;
        c_o_stall_id = !c_i_mem_ack;
        c_o_stall_ex = !c_i_mem_ack;
        c_o_stall_mem = !c_i_mem_ack;
        if (c_i_mem_ack) begin
          cnt_d = 8'd0;
          state_d = RUN;
        end else if (timeout) begin
          c_o_flush_mem = 1'b1;
          cause_d = '1;
          tpc_d = c_i_ex_pc;
          cnt_d = 8'd0;
          state_d = TRAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      TRAP, ILLEGAL: begin
        c_o_trap = 1'b1;
        c_o_redirect = 1'b1;
        c_o_redirect_pc = TRAP_VEC;
        c_o_flush_id = 1'b1;
        c_o_flush_ex = 1'b1;
        state_d = RUN;
      end
    endcase
    if (!c_rst) begin
      c_o_stall_if = 1'b0;
      c_o_stall_id = 1'b0;
      c_o_stall_ex = 1'b0;
      c_o_stall_mem = 1'b0;
      c_o_flush_id = 1'b0;
      c_o_flush_ex = 1'b0;
      c_o_flush_mem = 1'b0;
      c_o_redirect = 1'b0;
      c_o_redirect_pc = '0;
      c_o_trap = 1'b0;
    end
  end

  always_ff @(posedge c_clk or negedge c_rst) begin
    if (!c_rst) begin
      state_q <= RUN;
      cnt_q <= 8'd0;
      cause_q <= '0;
      tpc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cause_q <= cause_d;
      tpc_q <= tpc_d;
    end
  end

  assign c_o_trap_cause = cause_q;
  assign c_o_trap_pc = tpc_q;
  assign c_o_state = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_ctrl;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] rs1, rs2, ex_rd;
  logic use1, use2, ex_valid, ex_load, chg;
  logic [31:0] next_pc, ex_pc;
  logic [3:0] ex_exc;
  logic mem_req, mem_ack;

  logic s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, redir, trap;
  logic [31:0] rpc, tpc;
  logic [3:0] tcause;
  logic [1:0] state;

  pipeline_ctrl #(
    .AWIDTH(5), .PC_WIDTH(32), .EWIDTH(4),
    .TIMEOUT(TO), .TRAP_VEC(32'h0000_0100)
  ) dut (
    .c_clk(clk), .c_rst(rst),
    .c_i_id_rs1(rs1), .c_i_id_rs2(rs2),
    .c_i_id_use_rs1(use1), .c_i_id_use_rs2(use2),
    .c_i_ex_valid(ex_valid), .c_i_ex_load(ex_load),
    .c_i_ex_rd(ex_rd), .c_i_ex_change_pc(chg),
    .c_i_ex_next_pc(next_pc), .c_i_ex_pc(ex_pc),
    .c_i_ex_exception(ex_exc),
    .c_i_mem_req(mem_req), .c_i_mem_ack(mem_ack),
    .c_o_stall_if(s_if), .c_o_stall_id(s_id),
    .c_o_stall_ex(s_ex), .c_o_stall_mem(s_mem),
    .c_o_flush_id(f_id), .c_o_flush_ex(f_ex),
    .c_o_flush_mem(f_mem), .c_o_redirect(redir),
    .c_o_redirect_pc(rpc), .c_o_trap(trap),
    .c_o_trap_cause(tcause), .c_o_trap_pc(tpc),
    .c_o_state(state)
  );

  int errors = 0;
  int checks = 0;

  // model: mode 0 running, 1 waiting on memory, 2 entering trap
  int mode = 0;
  int nack = 0;
  logic [3:0] m_tc = 4'd0;
  logic [31:0] m_tp = 32'd0;

  // {stall_if,id,ex,mem, flush_id,ex,mem, redirect, trap}
  function automatic logic [8:0] ctl();
    return {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, redir, trap};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; ex_rd = 0;
    use1 = 0; use2 = 0; ex_valid = 0; ex_load = 0; chg = 0;
    next_pc = 0; ex_pc = 0; ex_exc = 0;
    mem_req = 0; mem_ack = 0;
  endtask

  // compare against the model, then advance one clock
  task automatic cyc();
    logic [8:0] e;
    logic [31:0] e_rpc;
    logic lu, ex_hit, busy;
    int nmode, nnack;
    logic [3:0] ntc;
    logic [31:0] ntp;
    #1;
    if (!rst) begin
      mode = 0; nack = 0; m_tc = 0; m_tp = 0;
    end
    e = '0; e_rpc = '0;
    nmode = mode; nnack = nack; ntc = m_tc; ntp = m_tp;
    lu = ex_valid && ex_load && ex_rd != 0 &&
         ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));
    ex_hit = ex_valid && ex_exc != 0;
    busy = mem_req && !mem_ack;
    if (rst) begin
      if (mode == 0) begin
        if (busy) begin
          e = 9'b1_1110_0000; nmode = 1; nnack = 1;
        end else if (ex_hit) begin
          e = 9'b0_0001_1000; nmode = 2; ntc = ex_exc; ntp = ex_pc;
        end else if (ex_valid && chg) begin
          e = 9'b0_0001_1010; e_rpc = next_pc;
        end else if (lu) begin
          e = 9'b1_1000_1000;
        end
      end else if (mode == 1) begin
        if (mem_ack) begin
          nmode = 0; nnack = 0;
        end else if (nack + 1 == TO) begin
          e = 9'b1_1110_0100; nmode = 2; ntc = 4'hF; ntp = ex_pc;
        end else begin
          e = 9'b1_1110_0000; nnack = nack + 1;
        end
      end else begin
        e = 9'b0_0001_1011; e_rpc = 32'h100; nmode = 0;
      end
    end
    chk("ctl", 64'(ctl()), 64'(e));
    if (e[1]) chk("redirect_pc", 64'(rpc), 64'(e_rpc));
    chk("state/trap regs", {26'd0, state, tcause, tpc},
        {26'd0, 2'(mode), m_tc, m_tp});
    @(posedge clk);
    if (rst) begin
      mode = nmode; nack = nnack; m_tc = ntc; m_tp = ntp;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset ctl", 64'(ctl()), 64'd0);
    chk("reset state", 64'(state), 64'd0);
    chk("reset trap regs", {28'd0, tcause, tpc}, 64'd0);
    cyc();
    rst = 1'b1;
    cyc();

    // load-use
    ex_valid = 1; ex_load = 1; ex_rd = 5; rs1 = 5; use1 = 1;
    #1 chk("load-use", 64'(ctl()), 64'h188);
    cyc();
    idle();
    #1 chk("load-use cleared", 64'(ctl()), 64'd0);
    cyc();
    ex_valid = 1; ex_load = 1; ex_rd = 0; rs1 = 0; use1 = 1;
    #1 chk("load-use x0", 64'(ctl()), 64'd0);
    cyc();

    // branch beats load-use
    ex_valid = 1; ex_load = 1; ex_rd = 5; rs1 = 5; use1 = 1;
    chg = 1; next_pc = 32'h40;
    #1 chk("branch ctl", 64'(ctl()), 64'h01A);
    chk("branch pc", 64'(rpc), 64'h40);
    cyc();
    idle();

    // memory wait, ack on 4th cycle
    mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mem stall", 64'(ctl()), 64'h1E0);
      chk("mem state", 64'(state), (i == 0) ? 64'd0 : 64'd1);
      cyc();
    end
    mem_ack = 1;
    #1 chk("mem ack ctl", 64'(ctl()), 64'd0);
    chk("mem ack state", 64'(state), 64'd1);
    cyc();
    idle();
    #1 chk("after ack state", 64'(state), 64'd0);
    cyc();

    // timeout
    mem_req = 1; ex_pc = 32'h0000_0aa0;
    for (int i = 1; i < TO; i++) cyc();
    #1 chk("timeout flush_mem", 64'(ctl()), 64'h1E4);
    cyc();
    idle();
    #1 chk("timeout trap", 64'(ctl()), 64'h01B);
    chk("timeout vec", 64'(rpc), 64'h100);
    chk("timeout cause", 64'(tcause), 64'hF);
    chk("timeout pc", 64'(tpc), 64'haa0);
    cyc();

    // exception beats branch
    ex_valid = 1; ex_exc = 4'd2; ex_pc = 32'h80;
    chg = 1; next_pc = 32'h44;
    #1 chk("exc flush", 64'(ctl()), 64'h018);
    cyc();
    idle();
    #1 chk("exc trap", 64'(ctl()), 64'h01B);
    chk("exc vec", 64'(rpc), 64'h100);
    cyc();
    #1 chk("exc held", {28'd0, tcause, tpc}, {28'd0, 4'd2, 32'h80});
    chk("exc back to run", 64'(state), 64'd0);
    cyc();

    // reset in the middle of a memory wait
    mem_req = 1;
    cyc();
    cyc();
    rst = 1'b0;
    #1 chk("mid-reset ctl", 64'(ctl()), 64'd0);
    chk("mid-reset state", 64'(state), 64'd0);
    cyc();
    idle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 chk("post-reset no trap", 64'(trap), 64'd0);
      cyc();
    end

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit slow;
      slow = ((i / 400) % 2) == 1;
      rst = ($urandom_range(0, 599) != 0);
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      use1 = 1'($urandom);
      use2 = 1'($urandom);
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_load = 1'($urandom);
      chg = ($urandom_range(0, 3) == 0);
      next_pc = $urandom & 32'hFFFF_FFFC;
      ex_pc = $urandom & 32'hFFFF_FFFC;
      ex_exc = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
      mem_req = ($urandom_range(0, 3) == 0) || (slow && mode == 1);
      mem_ack = slow ? ($urandom_range(0, 39) == 0)
                     : ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
